// File: rtl/unique_history_mtf_pkg.sv
// Shared types and sizing helpers for the move-to-front unique-history block.
// Also used by its match encoder.
package unique_history_pkg;

    // What the update stage does to the list on the coming edge.
    typedef enum logic [1:0] {
        UPD_IDLE,
        UPD_HIT,
        UPD_FILL,
        UPD_EVICT
    } upd_op_e;

    // Index width that never collapses to zero bits for tiny lists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unique_history_mtf_match_enc.sv
// Comparator bank plus priority encoder.
// Reports whether the key sits in any valid entry and the lowest such index.
module uh_match_enc
    import unique_history_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int IDX_W = clog2_min1(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] i_entries,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DATA_W-1:0]            i_key,
    output logic                         o_match,
    output logic [IDX_W-1:0]             o_match_idx
);

    logic [DEPTH-1:0] w_eq;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_eq[gi] = i_valid[gi] && (i_entries[gi] == i_key);
        end
    endgenerate

    assign o_match = |w_eq;

    // Scan from the tail so the lowest matching index is written last.
    always_comb begin
        o_match_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_eq[k]) begin
                o_match_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/unique_history_mtf.sv
// Ordered list of the last DEPTH distinct samples, most recent first, with move-to-front.
// A registered input stage feeds the list update, so a sample reaches entry 0 two edges later.
module unique_history_mtf
    import unique_history_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int IDX_W = clog2_min1(DEPTH),
    localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    clear_in,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DEPTH*DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]        out_valid,
    output logic [CNT_W-1:0]        count,
    output logic                    hit,
    output logic [IDX_W-1:0]        hit_idx,
    output logic                    evict_valid,
    output logic [DATA_W-1:0]       evict_data
);

    logic [DATA_W-1:0]             r_din;
    logic                          r_dvld;
    logic [DEPTH-1:0][DATA_W-1:0]  r_entry;
    logic [DEPTH-1:0]              r_valid;
    logic [CNT_W-1:0]              r_count;
    logic                          r_hit;
    logic [IDX_W-1:0]              r_hit_idx;
    logic                          r_evict_valid;
    logic [DATA_W-1:0]             r_evict_data;

    logic [DEPTH-1:0][DATA_W-1:0]  w_entry_next;
    logic                          w_match;
    logic [IDX_W-1:0]              w_match_idx;
    upd_op_e                       w_op;

    uh_match_enc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_match (
        .i_entries   (r_entry),
        .i_valid     (r_valid),
        .i_key       (r_din),
        .o_match     (w_match),
        .o_match_idx (w_match_idx)
    );

    // A full list is recognised by its tail being valid; a miss then evicts.
    always_comb begin
        w_op = UPD_IDLE;
        if (r_dvld) begin
            if (w_match) begin
                w_op = UPD_HIT;
            end else if (r_valid[DEPTH-1]) begin
                w_op = UPD_EVICT;
            end else begin
                w_op = UPD_FILL;
            end
        end
    end

    // Entry k takes its predecessor on a miss, or on a hit at or beyond k.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_load;
            assign w_load = (w_op == UPD_FILL) || (w_op == UPD_EVICT) ||
                            ((w_op == UPD_HIT) && (IDX_W'(gi) <= w_match_idx));
            if (gi == 0) begin : g_head
                assign w_entry_next[gi] = w_load ? r_din : r_entry[gi];
            end else begin : g_body
                assign w_entry_next[gi] = w_load ? r_entry[gi-1] : r_entry[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_din         <= '0;
            r_dvld        <= 1'b0;
            r_entry       <= '0;
            r_valid       <= '0;
            r_count       <= '0;
            r_hit         <= 1'b0;
            r_hit_idx     <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else if (clear_in) begin
            r_din         <= '0;
            r_dvld        <= 1'b0;
            r_entry       <= '0;
            r_valid       <= '0;
            r_count       <= '0;
            r_hit         <= 1'b0;
            r_hit_idx     <= '0;
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else begin
            r_din         <= data_in;
            r_dvld        <= in_valid;
            r_entry       <= w_entry_next;
            r_evict_valid <= 1'b0;
            case (w_op)
                UPD_HIT: begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= w_match_idx;
                end
                UPD_FILL: begin
                    r_hit     <= 1'b0;
                    r_hit_idx <= '0;
                    r_valid   <= {r_valid[DEPTH-2:0], 1'b1};
                    r_count   <= r_count + CNT_W'(1);
                end
                UPD_EVICT: begin
                    r_hit         <= 1'b0;
                    r_hit_idx     <= '0;
                    r_evict_valid <= 1'b1;
                    r_evict_data  <= r_entry[DEPTH-1];
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data    = r_entry;
    assign out_valid   = r_valid;
    assign count       = r_count;
    assign hit         = r_hit;
    assign hit_idx     = r_hit_idx;
    assign evict_valid = r_evict_valid;
    assign evict_data  = r_evict_data;

endmodule
